// File: rtl/arqui_pkg.sv
// Shared constants and source encodings for the arqui D-FIFO drain path.
package arqui_pkg;

    localparam int DATA_W      = 6;
    localparam int DRAIN_DEPTH = 3;

    typedef enum logic {
        SRC_D0 = 1'b0,
        SRC_D1 = 1'b1
    } src_e;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DRAIN_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Small ring buffer of {src, data} entries; push and pop may coincide.
module drain_skid_buf
    import arqui_pkg::*;
#(
    parameter int DATA_W = arqui_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  src_e              push_src,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output src_e              head_src,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ
);

    logic [DATA_W:0] mem_q [DRAIN_DEPTH];
    logic [DATA_W:0] mem_d [DRAIN_DEPTH];
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      occ_q, occ_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = {push_src, push_data};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_src  = src_e'(mem_q[rd_ptr_q][DATA_W]);
    assign head_data = mem_q[rd_ptr_q][DATA_W-1:0];
    assign occ       = occ_q;

endmodule

// File: rtl/d_fifo_drain.sv
// Round-robin drain of the D0/D1 destination FIFOs into one tagged stream
// with credit-based popping that covers the FIFOs' registered read latency.
module d_fifo_drain
    import arqui_pkg::*;
#(
    parameter int DATA_W = arqui_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              enable,
    input  logic              fifo_empty_d0,
    input  logic              fifo_empty_d1,
    input  logic [DATA_W-1:0] data_in_d0,
    input  logic [DATA_W-1:0] data_in_d1,
    input  logic              sink_ready,
    output logic              pop_d0,
    output logic              pop_d1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              src_out,
    output logic [CNT_W-1:0]  count_d0,
    output logic [CNT_W-1:0]  count_d1,
    output logic              idle_out
);

    logic             infl_q, infl_d;
    src_e             infl_src_q, infl_src_d;
    src_e             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] count_d0_q, count_d0_d;
    logic [CNT_W-1:0] count_d1_q, count_d1_d;
    logic             idle_q, idle_d;

    logic              go, grant_d0, grant_d1, xfer;
    logic [1:0]        occ;
    src_e              head_src;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] push_data;

    // Credit counts the in-flight word so a returning word always has a slot;
    // sink_ready is deliberately kept out of this path.
    always_comb begin
        go       = enable & reset_L & ((3'(occ) + 3'(infl_q)) < 3'(DRAIN_DEPTH));
        grant_d0 = 1'b0;
        grant_d1 = 1'b0;
        if (go) begin
            if (!fifo_empty_d0 && !fifo_empty_d1) begin
                grant_d0 = (last_grant_q == SRC_D1);
                grant_d1 = ~grant_d0;
            end else begin
                grant_d0 = ~fifo_empty_d0;
                grant_d1 = ~fifo_empty_d1;
            end
        end
    end

    always_comb begin
        xfer         = (occ != 2'd0) & sink_ready;
        infl_d       = grant_d0 | grant_d1;
        infl_src_d   = grant_d1 ? SRC_D1 : SRC_D0;
        last_grant_d = infl_d ? infl_src_d : last_grant_q;
        push_data    = (infl_src_q == SRC_D1) ? data_in_d1 : data_in_d0;

        count_d0_d = count_d0_q;
        count_d1_d = count_d1_q;
        if (xfer && head_src == SRC_D0 && count_d0_q != '1) begin
            count_d0_d = count_d0_q + CNT_W'(1);
        end
        if (xfer && head_src == SRC_D1 && count_d1_q != '1) begin
            count_d1_d = count_d1_q + CNT_W'(1);
        end

        idle_d = (occ == 2'd0) & ~infl_q & fifo_empty_d0 & fifo_empty_d1;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            infl_q       <= 1'b0;
            infl_src_q   <= SRC_D0;
            last_grant_q <= SRC_D1;
            count_d0_q   <= '0;
            count_d1_q   <= '0;
            idle_q       <= 1'b1;
        end else begin
            infl_q       <= infl_d;
            infl_src_q   <= infl_src_d;
            last_grant_q <= last_grant_d;
            count_d0_q   <= count_d0_d;
            count_d1_q   <= count_d1_d;
            idle_q       <= idle_d;
        end
    end

    drain_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (infl_q),
        .push_src  (infl_src_q),
        .push_data (push_data),
        .pop       (xfer),
        .head_src  (head_src),
        .head_data (head_data),
        .occ       (occ)
    );

    assign pop_d0    = grant_d0;
    assign pop_d1    = grant_d1;
    assign valid_out = (occ != 2'd0);
    assign data_out  = head_data;
    assign src_out   = head_src;
    assign count_d0  = count_d0_q;
    assign count_d1  = count_d1_q;
    assign idle_out  = idle_q;

endmodule

// File: tb/tb_d_fifo_drain.sv
// Scoreboard bench for d_fifo_drain with behavioural D0/D1 FIFO models.
module tb_d_fifo_drain;

    localparam int DW = 6;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty_d0 = 1'b1;
    logic          fifo_empty_d1 = 1'b1;
    logic [DW-1:0] data_in_d0 = '0;
    logic [DW-1:0] data_in_d1 = '0;
    logic          sink_ready = 1'b0;
    logic          pop_d0, pop_d1, valid_out, src_out, idle_out;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count_d0, count_d1;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          pop_log[$];
    logic [DW:0]   exp_q[$];

    always #5 clk = ~clk;

    d_fifo_drain #(
        .DATA_W (DW),
        .CNT_W  (CW)
    ) dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .enable        (enable),
        .fifo_empty_d0 (fifo_empty_d0),
        .fifo_empty_d1 (fifo_empty_d1),
        .data_in_d0    (data_in_d0),
        .data_in_d1    (data_in_d1),
        .sink_ready    (sink_ready),
        .pop_d0        (pop_d0),
        .pop_d1        (pop_d1),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .src_out       (src_out),
        .count_d0      (count_d0),
        .count_d1      (count_d1),
        .idle_out      (idle_out)
    );

    // FIFO models: read data registered one cycle after the pop.
    initial forever begin
        @(posedge clk);
        if (pop_d0 || pop_d1) begin
            checks++;
            if ((pop_d0 && pop_d1) || (pop_d0 && q0.size() == 0) || (pop_d1 && q1.size() == 0)) begin
                errors++;
                $display("FAIL pop_legal: pop_d0=%0b pop_d1=%0b d0_words=%0d d1_words=%0d, required single pop of non-empty FIFO",
                         pop_d0, pop_d1, q0.size(), q1.size());
            end else if (pop_d0) begin
                data_in_d0 <= q0.pop_front();
                pop_log.push_back(1'b0);
            end else begin
                data_in_d1 <= q1.pop_front();
                pop_log.push_back(1'b1);
            end
        end
        fifo_empty_d0 <= (q0.size() == 0);
        fifo_empty_d1 <= (q1.size() == 0);
    end

    initial begin : monitor
        logic [DW:0] exp_w;
        forever begin
            @(negedge clk);
            if (reset_L && valid_out && sink_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_word: got src=%0d data=0x%02h, required no transfer", src_out, data_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({src_out, data_out} !== exp_w) begin
                        errors++;
                        $display("FAIL out_word: got src=%0d data=0x%02h, required src=%0d data=0x%02h",
                                 src_out, data_out, exp_w[DW], exp_w[DW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        reset_L = 1'b0;
        tick(2);
        reset_L = 1'b1;
        pop_log.delete();
    endtask

    task automatic load(input logic src, input logic [DW-1:0] w, input logic expect_it);
        if (src) q1.push_back(w);
        else     q0.push_back(w);
        if (expect_it) exp_q.push_back({src, w});
    endtask

    task automatic pop_pattern(input string name, input int n, input logic [7:0] exp_bits);
        logic [7:0] pl;
        pl = '0;
        chk({name, "_count"}, pop_log.size(), n);
        for (int i = 0; i < pop_log.size() && i < 8; i++) pl[i] = pop_log[i];
        chk({name, "_order"}, pl, exp_bits);
    endtask

    initial begin
        // Reset then idle
        sink_ready = 1'b1;
        do_reset();
        chk("rst_pop_d0", pop_d0, 0);
        chk("rst_pop_d1", pop_d1, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_src", src_out, 0);
        chk("rst_idle", idle_out, 1);
        chk("rst_cnt0", count_d0, 0);
        chk("rst_cnt1", count_d1, 0);

        // Alternation with both sources
        load(0, 6'h2C, 1); load(1, 6'h0C, 1); load(0, 6'h2D, 1); load(1, 6'h0D, 1);
        tick(1);
        enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("alt_valid", valid_out, 1);
        end
        tick(3);
        pop_pattern("alt_pops", 4, 8'b0000_1010);
        chk("alt_cnt0", count_d0, 2);
        chk("alt_cnt1", count_d1, 2);
        chk("alt_drained", exp_q.size(), 0);
        enable = 1'b0;

        // Backpressure: credit limit stops popping after three words
        do_reset();
        sink_ready = 1'b0;
        for (int i = 0; i < 6; i++) load(0, DW'(6'h10 + i), 1);
        tick(1);
        enable = 1'b1;
        tick(8);
        chk("bp_pops", pop_log.size(), 3);
        chk("bp_pop_d0", pop_d0, 0);
        chk("bp_valid", valid_out, 1);
        chk("bp_head", data_out, 6'h10);
        sink_ready = 1'b1;
        tick(12);
        chk("bp_drained", exp_q.size(), 0);
        chk("bp_total_pops", pop_log.size(), 6);
        chk("bp_cnt0_sat", count_d0, 3);
        chk("bp_cnt1", count_d1, 0);
        enable = 1'b0;

        // Single source at full rate
        do_reset();
        for (int i = 0; i < 4; i++) load(0, DW'(6'h20 + i), 1);
        tick(1);
        enable = 1'b1;
        @(posedge clk);
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("ss_valid", valid_out, 1);
        end
        tick(3);
        pop_pattern("ss_pops", 4, 8'b0000_0000);
        chk("ss_cnt0", count_d0, 3);
        chk("ss_cnt1", count_d1, 0);
        chk("ss_drained", exp_q.size(), 0);
        chk("ss_idle", idle_out, 1);
        enable = 1'b0;

        // Enable dropped in the cycle of a pop
        do_reset();
        load(0, 6'h30, 1); load(0, 6'h31, 0); load(0, 6'h32, 0);
        tick(1);
        enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        tick(6);
        chk("en_pops", pop_log.size(), 1);
        chk("en_delivered", exp_q.size(), 0);
        chk("en_cnt0", count_d0, 1);
        chk("en_valid", valid_out, 0);
        exp_q.push_back({1'b0, 6'h31});
        exp_q.push_back({1'b0, 6'h32});
        enable = 1'b1;
        tick(6);
        chk("en_resume_pops", pop_log.size(), 3);
        chk("en_resume_drained", exp_q.size(), 0);
        chk("en_resume_cnt0", count_d0, 3);
        enable = 1'b0;

        // Saturation, then reset with two buffered and one in flight
        do_reset();
        for (int i = 0; i < 5; i++) load(0, DW'(6'h01 + i), 1);
        tick(1);
        enable = 1'b1;
        tick(10);
        chk("sat_cnt0", count_d0, 3);
        chk("sat_drained", exp_q.size(), 0);
        sink_ready = 1'b0;
        load(0, 6'h38, 0); load(0, 6'h39, 0); load(0, 6'h3A, 0);
        tick(1);
        tick(3);
        chk("mr_valid_before", valid_out, 1);
        chk("mr_head_before", data_out, 6'h38);
        reset_L    = 1'b0;
        sink_ready = 1'b1;
        tick(1);
        reset_L = 1'b1;
        enable  = 1'b0;
        chk("mr_valid", valid_out, 0);
        chk("mr_cnt0", count_d0, 0);
        chk("mr_cnt1", count_d1, 0);
        tick(3);
        chk("mr_dropped", valid_out, 0);
        chk("mr_no_words", exp_q.size(), 0);
        chk("mr_idle", idle_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
